// File: rtl/xbus_uart_pkg.sv
// Shared definitions for the xbus UART transmitter: register map, bit positions,
// transmitter state encoding and the reset baud divisor.
package xbus_uart_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int unsigned STATUS_FULL_BIT  = 0;
  localparam int unsigned STATUS_EMPTY_BIT = 1;
  localparam int unsigned STATUS_BUSY_BIT  = 2;
  localparam int unsigned STATUS_OVF_BIT   = 3;
  localparam int unsigned STATUS_CNT_LSB   = 8;

  localparam int unsigned CTRL_TX_EN_BIT  = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;

  localparam int unsigned DIV_W = 16;
  localparam logic [DIV_W-1:0] DEFAULT_BAUD_DIV = 16'd868;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/xbus_sync_fifo.sv
// Byte-wide synchronous FIFO with first-word fall-through read data.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module xbus_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is accepted when the head is leaving the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/xbus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the xbus: four registers in front of a
// byte FIFO feeding a START/DATA/STOP serialiser.
module xbus_uart_tx
  import xbus_uart_pkg::*;
#(
  parameter int unsigned      FIFO_DEPTH  = 8,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DEFAULT_BAUD_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        xbus_sel,
  input  logic        xbus_we,
  input  logic [3:0]  xbus_be,
  input  logic [31:0] xbus_addr,
  input  logic [31:0] xbus_wdata,
  output logic [31:0] xbus_rdata,
  output logic        uart_txd,
  output logic        tx_irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  tx_state_e        state_q, state_d;
  logic [DIV_W-1:0] baud_div_q, baud_div_d;
  logic [DIV_W-1:0] frame_div_q, frame_div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             txd_q, txd_d;
  logic             tx_en_q, tx_en_d;
  logic             irq_en_q, irq_en_d;
  logic             ovf_q, ovf_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_dout;
  logic [AW:0]      fifo_count;
  logic             wr_c, busy_c, bit_last_c;
  logic [1:0]       reg_sel_c;
  logic [DIV_W-1:0] period_c;
  logic             unused_c;

  assign unused_c  = ^{xbus_addr[31:4], xbus_addr[1:0], xbus_wdata[31:16]};
  assign reg_sel_c = xbus_addr[3:2];
  assign wr_c      = xbus_sel & xbus_we;
  assign busy_c    = (state_q != ST_IDLE);
  assign fifo_push = wr_c & (reg_sel_c == REG_TXDATA) & xbus_be[0];

  xbus_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (xbus_wdata[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Register writes; overflow only when the full FIFO is not draining this cycle.
  always_comb begin
    baud_div_d = baud_div_q;
    tx_en_d    = tx_en_q;
    irq_en_d   = irq_en_q;
    ovf_d      = ovf_q;
    if (fifo_push & fifo_full & ~fifo_pop) ovf_d = 1'b1;
    if (wr_c) begin
      unique case (reg_sel_c)
        REG_STATUS: begin
          if (xbus_be[0] & xbus_wdata[STATUS_OVF_BIT]) ovf_d = 1'b0;
        end
        REG_BAUDDIV: begin
          if (xbus_be[0]) baud_div_d[7:0]  = xbus_wdata[7:0];
          if (xbus_be[1]) baud_div_d[15:8] = xbus_wdata[15:8];
        end
        REG_CTRL: begin
          if (xbus_be[0]) begin
            tx_en_d  = xbus_wdata[CTRL_TX_EN_BIT];
            irq_en_d = xbus_wdata[CTRL_IRQ_EN_BIT];
          end
        end
        default: ;
      endcase
    end
  end

  assign period_c   = (frame_div_q == '0) ? DIV_W'(1) : frame_div_q;
  assign bit_last_c = (cnt_q == period_c - DIV_W'(1));

  // Serialiser: txd is registered from the next-state decision so a pop at E1
  // puts the start bit on the line from E1.
  always_comb begin
    state_d     = state_q;
    frame_div_d = frame_div_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    txd_d       = txd_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (tx_en_q & ~fifo_empty) begin
          fifo_pop    = 1'b1;
          shift_d     = fifo_dout;
          frame_div_d = baud_div_q;
          cnt_d       = '0;
          txd_d       = 1'b0;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        cnt_d = cnt_q + DIV_W'(1);
        if (bit_last_c) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          txd_d     = shift_q[0];
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        cnt_d = cnt_q + DIV_W'(1);
        if (bit_last_c) begin
          cnt_d     = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          txd_d     = shift_q[1];
          if (bit_idx_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        cnt_d = cnt_q + DIV_W'(1);
        if (bit_last_c) begin
          cnt_d = '0;
          if (tx_en_q & ~fifo_empty) begin
            fifo_pop    = 1'b1;
            shift_d     = fifo_dout;
            frame_div_d = baud_div_q;
            txd_d       = 1'b0;
            state_d     = ST_START;
          end else begin
            txd_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      baud_div_q  <= DEFAULT_DIV;
      frame_div_q <= DEFAULT_DIV;
      cnt_q       <= '0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      txd_q       <= 1'b1;
      tx_en_q     <= 1'b1;
      irq_en_q    <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_div_q  <= baud_div_d;
      frame_div_q <= frame_div_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      txd_q       <= txd_d;
      tx_en_q     <= tx_en_d;
      irq_en_q    <= irq_en_d;
      ovf_q       <= ovf_d;
    end
  end

  // Read mux; only ever drives data for a selected load.
  always_comb begin
    xbus_rdata = '0;
    if (xbus_sel & ~xbus_we) begin
      unique case (reg_sel_c)
        REG_STATUS: begin
          xbus_rdata[STATUS_FULL_BIT]  = fifo_full;
          xbus_rdata[STATUS_EMPTY_BIT] = fifo_empty;
          xbus_rdata[STATUS_BUSY_BIT]  = busy_c;
          xbus_rdata[STATUS_OVF_BIT]   = ovf_q;
          xbus_rdata[STATUS_CNT_LSB +: 8] = 8'(fifo_count);
        end
        REG_BAUDDIV: xbus_rdata[DIV_W-1:0] = baud_div_q;
        REG_CTRL: begin
          xbus_rdata[CTRL_TX_EN_BIT]  = tx_en_q;
          xbus_rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
        end
        default: ;
      endcase
    end
  end

  assign uart_txd = txd_q;
  assign tx_irq   = irq_en_q & fifo_empty & ~busy_c;

endmodule

// File: tb/tb_xbus_uart_tx.sv
// Directed self-checking bench for xbus_uart_tx: register access, framing,
// overflow, byte lanes, back-to-back frames with interrupt, and mid-frame reset.
module tb_xbus_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        xbus_sel;
  logic        xbus_we;
  logic [3:0]  xbus_be;
  logic [31:0] xbus_addr;
  logic [31:0] xbus_wdata;
  logic [31:0] xbus_rdata;
  logic        uart_txd;
  logic        tx_irq;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] A_TXDATA  = 32'h0;
  localparam logic [31:0] A_STATUS  = 32'h4;
  localparam logic [31:0] A_BAUDDIV = 32'h8;
  localparam logic [31:0] A_CTRL    = 32'hC;

  always #5 clk = ~clk;

  xbus_uart_tx #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd868)) dut (
    .clk        (clk),
    .rst        (rst),
    .xbus_sel   (xbus_sel),
    .xbus_we    (xbus_we),
    .xbus_be    (xbus_be),
    .xbus_addr  (xbus_addr),
    .xbus_wdata (xbus_wdata),
    .xbus_rdata (xbus_rdata),
    .uart_txd   (uart_txd),
    .tx_irq     (tx_irq)
  );

  // Drive a store that commits on the next rising edge; returns 1 time unit after it.
  task automatic bus_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    xbus_sel   = 1'b1;
    xbus_we    = 1'b1;
    xbus_addr  = a;
    xbus_be    = be;
    xbus_wdata = d;
    @(posedge clk);
    #1;
    xbus_sel = 1'b0;
    xbus_we  = 1'b0;
    xbus_be  = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    xbus_sel  = 1'b1;
    xbus_we   = 1'b0;
    xbus_addr = a;
    #1;
    d = xbus_rdata;
    xbus_sel = 1'b0;
  endtask

  // Read STATUS without consuming an edge (called 1 time unit after a rising edge).
  task automatic peek_status(output logic [31:0] d);
    xbus_sel  = 1'b1;
    xbus_we   = 1'b0;
    xbus_addr = A_STATUS;
    #1;
    d = xbus_rdata;
    xbus_sel = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int bit_no);
    if (bit_no == 0) return 1'b0;
    if (bit_no >= 9) return 1'b1;
    return b[bit_no-1];
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    bus_read(A_STATUS, d);
    n_checks++;
    if (d !== 32'h0000_0002) begin n_fail++; $display("FAIL reset_status got %h exp %h", d, 32'h2); end
    bus_read(A_BAUDDIV, d);
    n_checks++;
    if (d !== 32'h0000_0364) begin n_fail++; $display("FAIL reset_bauddiv got %h exp %h", d, 32'h364); end
    bus_read(A_CTRL, d);
    n_checks++;
    if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL reset_ctrl got %h exp %h", d, 32'h1); end
    bus_read(A_TXDATA, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_txdata_read got %h exp 0", d); end
    n_checks++;
    if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd got %b exp 1", uart_txd); end
    n_checks++;
    if (tx_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b exp 0", tx_irq); end
  endtask

  task automatic test_single_frame();
    logic [31:0] d;
    logic        exp;
    bus_write(A_BAUDDIV, 4'b0011, 32'h0000_0004);
    bus_write(A_TXDATA, 4'b0001, 32'h0000_00A5);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      exp = frame_bit(8'hA5, i / 4);
      peek_status(d);
      n_checks++;
      if (uart_txd !== exp) begin
        n_fail++; $display("FAIL frame_a5_txd cycle %0d got %b exp %b", i, uart_txd, exp);
      end
      n_checks++;
      if (d[2] !== 1'b1) begin n_fail++; $display("FAIL frame_a5_busy cycle %0d got %b exp 1", i, d[2]); end
    end
    @(posedge clk);
    #1;
    peek_status(d);
    n_checks++;
    if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL frame_a5_idle_txd got %b exp 1", uart_txd); end
    n_checks++;
    if (d !== 32'h0000_0002) begin n_fail++; $display("FAIL frame_a5_done_status got %h exp %h", d, 32'h2); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d;
    bus_write(A_CTRL, 4'b0001, 32'h0);
    bus_write(A_TXDATA, 4'b0010, 32'h0000_5500);
    bus_read(A_STATUS, d);
    n_checks++;
    if (d !== 32'h0000_0002) begin n_fail++; $display("FAIL lane_txdata_be0010 got %h exp %h", d, 32'h2); end
    bus_write(A_BAUDDIV, 4'b0010, 32'hFFFF_0300);
    bus_read(A_BAUDDIV, d);
    n_checks++;
    if (d !== 32'h0000_0304) begin n_fail++; $display("FAIL lane_baud_hi got %h exp %h", d, 32'h304); end
    bus_write(A_BAUDDIV, 4'b0011, 32'h0000_0002);
    bus_read(A_BAUDDIV, d);
    n_checks++;
    if (d !== 32'h0000_0002) begin n_fail++; $display("FAIL lane_baud_half got %h exp %h", d, 32'h2); end
    bus_write(A_CTRL, 4'b0010, 32'h0000_0003);
    bus_read(A_CTRL, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL lane_ctrl_be0010 got %h exp 0", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    for (int i = 0; i < 9; i++) bus_write(A_TXDATA, 4'b0001, 32'(8'h10 + i));
    bus_read(A_STATUS, d);
    n_checks++;
    if (d !== 32'h0000_0809) begin n_fail++; $display("FAIL ovf_status got %h exp %h", d, 32'h809); end
    bus_write(A_STATUS, 4'b0001, 32'h0000_0008);
    bus_read(A_STATUS, d);
    n_checks++;
    if (d !== 32'h0000_0801) begin n_fail++; $display("FAIL ovf_clear got %h exp %h", d, 32'h801); end
    bus_write(A_TXDATA, 4'b0010, 32'h0000_7700);
    bus_read(A_STATUS, d);
    n_checks++;
    if (d !== 32'h0000_0801) begin n_fail++; $display("FAIL ovf_be0010_full got %h exp %h", d, 32'h801); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [7:0]  b;
    logic        exp;
    do_reset();
    bus_write(A_CTRL, 4'b0001, 32'h0);
    bus_write(A_BAUDDIV, 4'b0011, 32'h0000_0002);
    bus_write(A_TXDATA, 4'b0001, 32'h0000_003C);
    bus_write(A_TXDATA, 4'b0001, 32'h0000_0081);
    bus_write(A_CTRL, 4'b0001, 32'h0000_0003);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      b   = (i < 20) ? 8'h3C : 8'h81;
      exp = frame_bit(b, (i % 20) / 2);
      n_checks++;
      if (uart_txd !== exp) begin
        n_fail++; $display("FAIL b2b_txd cycle %0d got %b exp %b", i, uart_txd, exp);
      end
      n_checks++;
      if (tx_irq !== 1'b0) begin n_fail++; $display("FAIL b2b_irq_early cycle %0d got %b exp 0", i, tx_irq); end
    end
    @(posedge clk);
    #1;
    peek_status(d);
    n_checks++;
    if (tx_irq !== 1'b1) begin n_fail++; $display("FAIL b2b_irq_rise got %b exp 1", tx_irq); end
    n_checks++;
    if (d !== 32'h0000_0002) begin n_fail++; $display("FAIL b2b_done_status got %h exp %h", d, 32'h2); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    logic        stayed_high;
    bus_write(A_CTRL, 4'b0001, 32'h0);
    bus_write(A_BAUDDIV, 4'b0011, 32'h0000_0004);
    bus_write(A_TXDATA, 4'b0001, 32'h0000_0000);
    bus_write(A_TXDATA, 4'b0001, 32'h0000_0000);
    bus_write(A_CTRL, 4'b0001, 32'h0000_0001);
    repeat (7) @(posedge clk);
    #1;
    peek_status(d);
    n_checks++;
    if (uart_txd !== 1'b0 || d[2] !== 1'b1) begin
      n_fail++; $display("FAIL midrst_in_data txd %b busy %b exp 0 1", uart_txd, d[2]);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL midrst_txd got %b exp 1", uart_txd); end
    peek_status(d);
    n_checks++;
    if (d !== 32'h0000_0002) begin n_fail++; $display("FAIL midrst_status got %h exp %h", d, 32'h2); end
    @(negedge clk);
    rst = 1'b0;
    stayed_high = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (uart_txd !== 1'b1) stayed_high = 1'b0;
    end
    n_checks++;
    if (stayed_high !== 1'b1) begin n_fail++; $display("FAIL midrst_no_send got %b exp 1", stayed_high); end
    bus_read(A_STATUS, d);
    n_checks++;
    if (d !== 32'h0000_0002) begin n_fail++; $display("FAIL midrst_after_status got %h exp %h", d, 32'h2); end
  endtask

  initial begin
    rst        = 1'b1;
    xbus_sel   = 1'b0;
    xbus_we    = 1'b0;
    xbus_be    = 4'h0;
    xbus_addr  = 32'h0;
    xbus_wdata = 32'h0;
    test_reset();
    test_single_frame();
    test_byte_lanes();
    test_overflow();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xbus_uart_tx.md
# xbus_uart_tx

Memory-mapped UART transmitter acting as an xbus responder. It decodes core-side xbus stores/loads (byte-enable, word-aligned address, lane-aligned data) into four 32-bit registers, buffers written bytes in a FIFO and serialises them 8N1 on `uart_txd`. It sits behind the system address decoder, which drives `xbus_sel`.

## Interface
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, ≥2.
- `DEFAULT_DIV`, 16'd868: reset value of BAUDDIV, in clock cycles per bit.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `xbus_sel` in 1: access targets this block.
- `xbus_we` in 1: 1 = write, 0 = read.
- `xbus_be` in 4: byte-lane enables, lane i = `wdata[8i+7:8i]`.
- `xbus_addr` in 32: only `[3:2]` decoded; `[1:0]` ignored.
- `xbus_wdata` in 32: lane-aligned write data.
- `xbus_rdata` out 32: full-word read data; combinational.
- `uart_txd` out 1: serial output, idle high.
- `tx_irq` out 1: level interrupt.

## Operation
- Register map (`addr[3:2]`):
  - 0 TXDATA: a write with `be[0]=1` pushes `wdata[7:0]`; reads return 0.
  - 1 STATUS:
    - bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky).
    - bits[15:8] FIFO count.
    - Writing 1 to bit3 with `be[0]` clears overflow; all other bits are read-only.
  - 2 BAUDDIV: bits[15:0], per-lane writes via `be[1:0]`; upper bits read 0.
  - 3 CTRL: bit0 tx_en (reset 1), bit1 irq_en (reset 0); written via `be[0]`.
- Write commits at the clock edge when `xbus_sel & xbus_we`. Lanes with `be=0` are untouched.
- Reads have no side effects. `xbus_rdata` = 0 when `xbus_sel=0` or `xbus_we=1`.
- TXDATA write when the FIFO is full and no pop occurs that cycle: byte dropped, overflow set.
- TXDATA write when full, simultaneous with a pop: push accepted, count unchanged.
- FSM states IDLE → START → DATA → STOP → IDLE/START:
  - IDLE: if tx_en and FIFO non-empty, pop a byte, latch the divisor into `frame_div`, go to START.
  - START: drive 0 for one bit period.
  - DATA: drive 8 bits, LSB first, one period each, 3-bit index.
  - STOP: drive 1 for one period. On the final cycle, if tx_en and non-empty, pop and go directly to START (back-to-back); otherwise go to IDLE.
- Bit period = `max(frame_div,1)` cycles. BAUDDIV writes mid-frame affect only the next frame.
- Clearing tx_en mid-frame lets the current frame finish; no further pops.
- `tx_irq` = irq_en & empty & ~busy.
- Reset values: `uart_txd`=1, FSM IDLE, FIFO empty, count 0, overflow 0, BAUDDIV=`DEFAULT_DIV`, CTRL=2'b01, `tx_irq`=0.
- Reset asserted mid-frame aborts the frame at the next edge and discards FIFO contents.

## Timing
- Register or FIFO write at edge E0: the new value is visible on `xbus_rdata` after E0.
- FIFO non-empty after E0 while IDLE: pop and START entry at E1, `uart_txd`=0 from E1.
- Frame = 10 × bit period cycles.
- Back-to-back frames have no idle gap.
- Pop and a push to a full FIFO may coincide.
- `busy` rises at E1 and falls at the edge that ends STOP with the FIFO empty.

## Structure
- Shared package `xbus_uart_pkg`:
  - register offsets;
  - STATUS/CTRL bit positions;
  - FSM state encoding (2-bit);
  - `DEFAULT_DIV` constant.
- Sub-module `xbus_sync_fifo`:
  - 8-bit width, `FIFO_DEPTH` entries;
  - ports push/pop/full/empty/count;
  - pointers wrap modulo depth, extra pointer bit for full/empty.

## Test plan
- Reset, then read all four registers:
  - STATUS = 0x0000_0002;
  - BAUDDIV = 0x0000_0364;
  - CTRL = 0x1;
  - `uart_txd`=1.
- BAUDDIV=4, write 0xA5 to TXDATA → `uart_txd` = 0,1,0,1,0,0,1,0,1,1, each for 4 cycles, starting one edge after the write; busy=1 throughout.
- Write 9 bytes with tx_en=0 (depth 8) → count=8, full=1, overflow=1. Write 0x8 to STATUS → overflow=0, count still 8.
- Byte store with `be`=0010 to TXDATA → no push, count unchanged. Half store `be`=0011 to BAUDDIV with data 0x0002 → BAUDDIV=2.
- Two queued bytes with BAUDDIV=2 → 40 contiguous cycles of frames, no idle high between STOP and the second START. With irq_en=1, `tx_irq` rises the cycle after the second STOP ends.
- `rst` asserted during DATA → next cycle `uart_txd`=1, STATUS=0x2, and a pending FIFO byte is never sent.
